cti_commit_seq: RTL and testbench

CTI_COMMIT_SEQ -- requirements
Module: cti_commit_seq

---
 rtl/cti_commit_seq_pkg.sv | 14 +
 rtl/cti_lane_compact.sv | 34 +++
 rtl/cti_commit_seq.sv | 123 ++++++++++++
 tb/tb_cti_commit_seq.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/cti_commit_seq_pkg.sv
// Shared definitions for the CTI commit sequencer: drain-stage states and
// the widths used by lane compaction.
package cti_commit_seq_pkg;

  localparam int CW     = 2;  // default number of commit lanes
  localparam int LANE_W = 2;  // lane index width, covers up to 4 lanes
  localparam int CNT_W  = 3;  // write count width, covers 0..4 writes

  typedef enum logic {
    DRAIN_EMPTY = 1'b0,
    DRAIN_HOLD  = 1'b1
  } drain_state_e;

endpackage

// File: rtl/cti_lane_compact.sv
// Packs the set bits of a lane-valid vector onto consecutive write ports:
// port j takes the lane holding the j-th set bit, counted from lane 0.
module cti_lane_compact #(
  parameter int CW = cti_commit_seq_pkg::CW
) (
  input  logic [CW-1:0]                               valid,
  output logic [CW*cti_commit_seq_pkg::LANE_W-1:0]    port_lane,
  output logic [CW-1:0]                               port_used,
  output logic [cti_commit_seq_pkg::CNT_W-1:0]        wcount
);
  import cti_commit_seq_pkg::*;

  logic [CNT_W-1:0] below [CW];

  always_comb begin
    port_lane = '0;
    port_used = '0;
    wcount    = '0;
    for (int k = 0; k < CW; k++) begin
      below[k] = wcount;
      wcount   = wcount + CNT_W'(valid[k]);
    end
    // A lane lands on the port whose number equals the set bits below it.
    for (int p = 0; p < CW; p++) begin
      for (int k = 0; k < CW; k++) begin
        if (valid[k] && (below[k] == CNT_W'(p))) begin
          port_lane[p*LANE_W +: LANE_W] = LANE_W'(k);
          port_used[p]                  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/cti_commit_seq.sv
// Sequences CTI commits into an external circular RAM and drains entries in
// order through a one-entry output register towards the predictor update.
module cti_commit_seq #(
  parameter int DEPTH = 16,
  parameter int INDEX = 4,
  parameter int WIDTH = 8,
  parameter int CW    = cti_commit_seq_pkg::CW
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [CW-1:0]         commit_valid_i,
  input  logic [CW*WIDTH-1:0]   commit_data_i,
  output logic                  commit_stall_o,
  output logic [CW*INDEX-1:0]   ram_waddr_o,
  output logic [CW*WIDTH-1:0]   ram_wdata_o,
  output logic [CW-1:0]         ram_we_o,
  output logic [INDEX-1:0]      ram_raddr_o,
  input  logic [WIDTH-1:0]      ram_rdata_i,
  output logic                  upd_valid_o,
  output logic [WIDTH-1:0]      upd_data_o,
  input  logic                  upd_ready_i,
  output logic [INDEX:0]        count_o,
  output logic                  overflow_o
);
  import cti_commit_seq_pkg::*;

  localparam int CNTW = INDEX + 1;

  logic [INDEX-1:0]       head;
  logic [INDEX-1:0]       tail;
  logic [INDEX:0]         count;
  logic [WIDTH-1:0]       upd_data;
  logic                   overflow;
  drain_state_e           state;
  drain_state_e           state_nxt;

  logic [CW*LANE_W-1:0]   port_lane;
  logic [CW-1:0]          port_used;
  logic [CNT_W-1:0]       wcount;
  logic                   stall;
  logic                   wr_ok;
  logic                   drain;
  logic [INDEX:0]         nwr;

  cti_lane_compact #(
    .CW (CW)
  ) u_compact (
    .valid     (commit_valid_i),
    .port_lane (port_lane),
    .port_used (port_used),
    .wcount    (wcount)
  );

  // Stall depends only on registered occupancy so it never loops back
  // through the commit lanes.
  assign stall = (DEPTH - int'(count)) < CW;
  assign wr_ok = !reset && !stall;
  assign nwr   = wr_ok ? CNTW'(wcount) : '0;

  always_comb begin
    ram_we_o    = '0;
    ram_waddr_o = '0;
    ram_wdata_o = '0;
    for (int p = 0; p < CW; p++) begin
      ram_we_o[p]                   = wr_ok && port_used[p];
      ram_waddr_o[p*INDEX +: INDEX] = tail + INDEX'(p);
      ram_wdata_o[p*WIDTH +: WIDTH] =
        commit_data_i[int'(port_lane[p*LANE_W +: LANE_W])*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    state_nxt = state;
    drain     = 1'b0;
    case (state)
      DRAIN_EMPTY: begin
        if (count != '0) begin
          drain     = 1'b1;
          state_nxt = DRAIN_HOLD;
        end
      end
      DRAIN_HOLD: begin
        if (upd_ready_i) begin
          if (count != '0) drain = 1'b1;
          else             state_nxt = DRAIN_EMPTY;
        end
      end
      default: state_nxt = DRAIN_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= DRAIN_EMPTY;
    else       state <= state_nxt;
  end

  // Queue pointers, occupancy, output register and sticky drop flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      upd_data <= '0;
      overflow <= 1'b0;
    end else begin
      if (drain) begin
        head     <= head + INDEX'(1);
        upd_data <= ram_rdata_i;
      end
      tail  <= tail + INDEX'(nwr);
      count <= count + nwr - CNTW'(drain);
      if (stall && (commit_valid_i != '0)) overflow <= 1'b1;
    end
  end

  assign commit_stall_o = stall;
  assign ram_raddr_o    = head;
  assign upd_valid_o    = (state == DRAIN_HOLD);
  assign upd_data_o     = upd_data;
  assign count_o        = count;
  assign overflow_o     = overflow;

endmodule

// File: tb/tb_cti_commit_seq.sv
// Bench for cti_commit_seq: queue-level reference model, external RAM model,
// directed scenarios with literal expectations and a randomized run.
module tb_cti_commit_seq;
  localparam int DEPTH = 16;
  localparam int INDEX = 4;
  localparam int WIDTH = 8;
  localparam int CW    = 2;

  logic                clk = 1'b0;
  logic                reset;
  logic [CW-1:0]       commit_valid_i;
  logic [CW*WIDTH-1:0] commit_data_i;
  logic                commit_stall_o;
  logic [CW*INDEX-1:0] ram_waddr_o;
  logic [CW*WIDTH-1:0] ram_wdata_o;
  logic [CW-1:0]       ram_we_o;
  logic [INDEX-1:0]    ram_raddr_o;
  logic [WIDTH-1:0]    ram_rdata_i;
  logic                upd_valid_o;
  logic [WIDTH-1:0]    upd_data_o;
  logic                upd_ready_i;
  logic [INDEX:0]      count_o;
  logic                overflow_o;

  always #5 clk = ~clk;

  cti_commit_seq #(
    .DEPTH (DEPTH), .INDEX (INDEX), .WIDTH (WIDTH), .CW (CW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .commit_valid_i (commit_valid_i),
    .commit_data_i  (commit_data_i),
    .commit_stall_o (commit_stall_o),
    .ram_waddr_o    (ram_waddr_o),
    .ram_wdata_o    (ram_wdata_o),
    .ram_we_o       (ram_we_o),
    .ram_raddr_o    (ram_raddr_o),
    .ram_rdata_i    (ram_rdata_i),
    .upd_valid_o    (upd_valid_o),
    .upd_data_o     (upd_data_o),
    .upd_ready_i    (upd_ready_i),
    .count_o        (count_o),
    .overflow_o     (overflow_o)
  );

  // External commit RAM: synchronous write, combinational read.
  logic [WIDTH-1:0] mem [DEPTH];
  assign ram_rdata_i = mem[ram_raddr_o];
  always @(posedge clk)
    for (int p = 0; p < CW; p++)
      if (ram_we_o[p]) mem[ram_waddr_o[p*INDEX +: INDEX]] <= ram_wdata_o[p*WIDTH +: WIDTH];

  // Reference model: FIFO of queued entries plus the held output entry.
  logic [WIDTH-1:0] q[$];
  bit               hv;
  logic [WIDTH-1:0] hd;
  bit               ovf;
  int               mhead, mtail;
  bit               m_stl;

  logic [CW-1:0]       p_v;
  logic [CW*WIDTH-1:0] p_d;
  bit                  p_rdy, p_rst;

  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Drive one cycle's inputs and compare every output against the model.
  task automatic apply(input logic [CW-1:0] v, input logic [CW*WIDTH-1:0] d,
                       input bit rdy, input bit rst);
    int j;
    commit_valid_i = v;
    commit_data_i  = d;
    upd_ready_i    = rdy;
    reset          = rst;
    p_v = v; p_d = d; p_rdy = rdy; p_rst = rst;
    #3;
    m_stl = (DEPTH - q.size()) < CW;
    chk("stall", 32'(commit_stall_o), 32'(m_stl));
    chk("count", 32'(count_o), 32'(q.size()));
    chk("upd_valid", 32'(upd_valid_o), 32'(hv));
    chk("upd_data", 32'(upd_data_o), 32'(hd));
    chk("overflow", 32'(overflow_o), 32'(ovf));
    chk("raddr", 32'(ram_raddr_o), 32'(mhead));
    j = 0;
    if (!rst && !m_stl) begin
      for (int k = 0; k < CW; k++) begin
        if (v[k]) begin
          chk("we", 32'(ram_we_o[j]), 32'd1);
          chk("waddr", 32'(ram_waddr_o[j*INDEX +: INDEX]), 32'((mtail + j) % DEPTH));
          chk("wdata", 32'(ram_wdata_o[j*WIDTH +: WIDTH]), 32'(d[k*WIDTH +: WIDTH]));
          j++;
        end
      end
    end
    for (int p = j; p < CW; p++) chk("we_idle", 32'(ram_we_o[p]), 32'd0);
  endtask

  // Advance one clock and update the model from the inputs just applied.
  task automatic tick();
    @(posedge clk);
    if (p_rst) begin
      q.delete(); hv = 0; hd = '0; ovf = 0; mhead = 0; mtail = 0;
    end else begin
      if (q.size() > 0 && (!hv || p_rdy)) begin
        hd = q.pop_front(); hv = 1; mhead = (mhead + 1) % DEPTH;
      end else if (hv && p_rdy) begin
        hv = 0;
      end
      if (m_stl) begin
        if (p_v != '0) ovf = 1;
      end else begin
        for (int k = 0; k < CW; k++)
          if (p_v[k]) begin
            q.push_back(p_d[k*WIDTH +: WIDTH]);
            mtail = (mtail + 1) % DEPTH;
          end
      end
    end
    #1;
  endtask

  initial begin
    reset = 1'b1; commit_valid_i = '0; commit_data_i = '0; upd_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    q.delete(); hv = 0; hd = '0; ovf = 0; mhead = 0; mtail = 0;
    p_v = '0; p_d = '0; p_rdy = 0; p_rst = 1;

    // Reset state.
    apply('0, '0, 1, 0);
    chk("rst_count", 32'(count_o), 32'd0);
    chk("rst_uv", 32'(upd_valid_o), 32'd0);
    chk("rst_ud", 32'(upd_data_o), 32'd0);
    chk("rst_stall", 32'(commit_stall_o), 32'd0);
    chk("rst_we", 32'(ram_we_o), 32'd0);
    tick();

    // Single commit on lane 1 reaches the update port two cycles later.
    apply(2'b10, 16'hA53C, 1, 0);
    chk("lane1_we", 32'(ram_we_o), 32'd1);
    chk("lane1_addr", 32'(ram_waddr_o[INDEX-1:0]), 32'd0);
    chk("lane1_data", 32'(ram_wdata_o[WIDTH-1:0]), 32'hA5);
    tick();
    apply('0, '0, 1, 0); tick();
    apply('0, '0, 1, 0);
    chk("lat_uv", 32'(upd_valid_o), 32'd1);
    chk("lat_ud", 32'(upd_data_o), 32'hA5);
    tick();

    // Fill with ready low until stall, then one dropped commit.
    apply('0, '0, 0, 1); tick();
    for (int i = 0; i < 16; i++) begin
      apply(2'b01, 16'(8'h10 + i), 0, 0); tick();
    end
    apply(2'b01, 16'h0099, 0, 0);
    chk("full_count", 32'(count_o), 32'd15);
    chk("full_stall", 32'(commit_stall_o), 32'd1);
    chk("full_ovf", 32'(overflow_o), 32'd0);
    chk("full_we", 32'(ram_we_o), 32'd0);
    tick();
    apply('0, '0, 0, 0);
    chk("drop_ovf", 32'(overflow_o), 32'd1);
    tick();

    // Held entry stays stable while ready is low, next one follows ready.
    for (int i = 0; i < 4; i++) begin
      apply('0, '0, 0, 0);
      chk("hold_ud", 32'(upd_data_o), 32'h10);
      tick();
    end
    apply('0, '0, 1, 0); tick();
    apply('0, '0, 0, 0);
    chk("next_ud", 32'(upd_data_o), 32'h11);
    tick();
    for (int i = 0; i < 7; i++) begin
      apply('0, '0, 1, 0); tick();
    end

    // Reset mid-operation with commits present.
    apply(2'b11, 16'h7777, 1, 1);
    chk("midrst_count", 32'(count_o), 32'd7);
    chk("midrst_uv", 32'(upd_valid_o), 32'd1);
    chk("midrst_we", 32'(ram_we_o), 32'd0);
    tick();
    apply(2'b01, 16'h0055, 1, 0);
    chk("postrst_count", 32'(count_o), 32'd0);
    chk("postrst_uv", 32'(upd_valid_o), 32'd0);
    chk("postrst_raddr", 32'(ram_raddr_o), 32'd0);
    chk("postrst_waddr", 32'(ram_waddr_o[INDEX-1:0]), 32'd0);
    chk("postrst_ovf", 32'(overflow_o), 32'd0);
    tick();

    // Wrap: tail at 15 with a double commit.
    apply('0, '0, 1, 1); tick();
    for (int i = 0; i < 15; i++) begin
      apply(2'b01, 16'(8'h20 + i), 1, 0); tick();
    end
    apply(2'b11, 16'hBBAA, 1, 0);
    chk("wrap_a0", 32'(ram_waddr_o[INDEX-1:0]), 32'd15);
    chk("wrap_a1", 32'(ram_waddr_o[2*INDEX-1:INDEX]), 32'd0);
    tick();
    for (int i = 0; i < 5; i++) begin
      apply('0, '0, 1, 0); tick();
    end

    // Steady double commits with ready high until stall, then drain.
    for (int i = 0; i < 20; i++) begin
      apply(2'b11, 16'($urandom), 1, 0); tick();
    end
    for (int i = 0; i < 20; i++) begin
      apply('0, '0, 1, 0); tick();
    end

    // Randomized traffic with alternating ready bias and rare resets.
    for (int i = 0; i < 3000; i++) begin
      bit rdy;
      if (((i / 150) % 2) == 0) rdy = ($urandom_range(0, 3) != 0);
      else                      rdy = ($urandom_range(0, 3) == 0);
      apply(CW'($urandom_range(0, 3)), 16'($urandom), rdy, ($urandom_range(0, 299) == 0));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
